alu_mdu_seq: RTL and testbench
==============================

ALU_MDU_SEQ -- requirements
Module: alu_mdu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; power of two, 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port i_req_vld  input  1  request valid.
REQ-006 SHALL have port o_req_rdy  output  1  request accepted when high with i_req_vld.
REQ-007 SHALL have port i_alu_op  input  5  opcode.
REQ-008 SHALL have port i_operand_a  input  WIDTH  operand A (rs1).
REQ-009 SHALL have port i_operand_b  input  WIDTH  operand B (rs2/imm).
REQ-010 SHALL have port o_rsp_vld  output  1  result valid.
REQ-011 SHALL have port i_rsp_rdy  input  1  consumer accepts result.
REQ-012 SHALL have port o_alu_data  output  WIDTH  result.
REQ-013 SHALL have port o_insn_vld  output  1  opcode was legal; qualified by o_rsp_vld.

Function
REQ-014 Base opcodes (bit4=0) SHALL be: ADD 00000, SUB 01000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111.
REQ-015 M opcodes (bit4=1) SHALL be 1_0_fff, fff = MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111; any other code illegal.
REQ-016 States SHALL be IDLE, MUL, DIV, DONE; o_req_rdy = 1 only in IDLE.
REQ-017 IDLE, handshake with base or illegal op -> DONE next edge, result registered; latency 1 cycle.
REQ-018 IDLE, handshake with MUL* -> MUL; shift-add one bit/cycle, WIDTH cycles, then DONE; latency WIDTH+1.
REQ-019 IDLE, handshake with DIV*/REM* -> DIV; restoring divide one quotient bit/cycle, WIDTH cycles, then DONE; latency WIDTH+1.
REQ-020 Operands and op SHALL be captured at handshake; later input changes SHALL not affect the result.
REQ-021 Shifts SHALL use operand_b[SHW-1:0] only; SRA sign-fills.
REQ-022 SLT/SLTU SHALL return {WIDTH-1 zeros, lt}, signed/unsigned compare.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH; MUL = low WIDTH bits, MULH/MULHSU/MULHU = high WIDTH bits of 2*WIDTH product with signed*signed / signed*unsigned / unsigned*unsigned.
REQ-024 Signed divide SHALL operate on magnitudes; quotient sign = sign(a)^sign(b), remainder sign = sign(a); rounding toward zero.
REQ-025 Divide by zero SHALL give quotient all-ones, remainder = a, with no extra latency.
REQ-026 Signed overflow (a = most-negative, b = -1) SHALL give quotient = a, remainder 0.
REQ-027 Illegal op SHALL give o_alu_data = 0, o_insn_vld = 0; legal ops o_insn_vld = 1.
REQ-028 DONE: o_rsp_vld = 1, o_alu_data/o_insn_vld stable until i_rsp_rdy = 1; that edge -> IDLE.
REQ-029 No new request SHALL be accepted in MUL, DIV or DONE; i_req_vld there SHALL be ignored, not queued.
REQ-030 i_rsp_rdy outside DONE SHALL have no effect.

Reset
REQ-031 i_rst high at an edge SHALL force IDLE, o_rsp_vld = 0, o_alu_data = 0, o_insn_vld = 0, o_req_rdy = 1 next cycle, from any state.
REQ-032 Reset mid MUL/DIV SHALL abort the operation with no response ever produced for it.
REQ-033 Reset SHALL take priority over a simultaneous request handshake, which is dropped.

Verification
REQ-034 WIDTH=32: ADD a=0x7FFFFFFF b=1 -> o_rsp_vld 1 cycle after accept, data 0x80000000, insn_vld 1; SRA a=0x80000000 b=0x24 -> 0xF8000000.
REQ-035 MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE; MUL same -> 0x00000001; each valid exactly 33 cycles after accept.
REQ-036 DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=5 b=0 -> 0xFFFFFFFF; REM a=0x80000000 b=0xFFFFFFFF -> 0.
REQ-037 Backpressure: hold i_rsp_rdy=0 for 10 cycles in DONE -> data stable, o_req_rdy 0, extra i_req_vld ignored; release -> IDLE next cycle.
REQ-038 Assert i_rst at cycle 10 of a DIV -> IDLE next cycle, no o_rsp_vld; new ADD then completes normally.
REQ-039 Opcode 01111 -> o_alu_data 0, o_insn_vld 0, latency 1; repeat REQ-035 with WIDTH=8 (latency 9).

Source files
------------

// File: rtl/alu_mdu_seq.sv
// Sequential RV32IM-style execute unit: single-cycle base ALU plus
// bit-serial shift-add multiplier and restoring divider.
module alu_mdu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_vld,
    output logic             o_req_rdy,
    input  logic [4:0]       i_alu_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_rsp_vld,
    input  logic             i_rsp_rdy,
    output logic [WIDTH-1:0] o_alu_data,
    output logic             o_insn_vld
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, res_q;
    logic [SHW-1:0]       cnt_q;
    logic [2:0]           fn_q;
    logic                 negq_q, negr_q, insn_q;

    logic                 hs, is_m, last;
    logic [WIDTH-1:0]     a, b, base_res, mag_a, mag_b, mdu_res;
    logic                 base_ok, sa_en, sb_en, sgn_a, sgn_b;
    logic [SHW-1:0]       sh;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_rs;
    logic [WIDTH-1:0]     div_diff, div_nr, quo, rem;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod;

    assign a    = i_operand_a;
    assign b    = i_operand_b;
    assign sh   = b[SHW-1:0];
    assign hs   = i_req_vld && (state_q == IDLE);
    assign is_m = i_alu_op[4] && !i_alu_op[3];
    assign last = cnt_q == SHW'(WIDTH - 1);

    always_comb begin
        base_ok  = 1'b1;
        base_res = '0;
        unique case (i_alu_op)
            5'b00000: base_res = a + b;
            5'b01000: base_res = a - b;
            5'b00001: base_res = a << sh;
            5'b00010: base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            5'b00011: base_res = {{(WIDTH-1){1'b0}}, a < b};
            5'b00100: base_res = a ^ b;
            5'b00101: base_res = a >> sh;
            5'b01101: base_res = $signed(a) >>> sh;
            5'b00110: base_res = a | b;
            5'b00111: base_res = a & b;
            default:  base_ok  = 1'b0;
        endcase
    end

    // Signed M ops run on magnitudes; the sign is re-applied at the end.
    always_comb begin
        if (i_alu_op[2]) begin
            sa_en = !i_alu_op[0];
            sb_en = !i_alu_op[0];
        end else begin
            sa_en = i_alu_op[1:0] == 2'b01 || i_alu_op[1:0] == 2'b10;
            sb_en = i_alu_op[1:0] == 2'b01;
        end
    end

    assign sgn_a = sa_en && a[WIDTH-1];
    assign sgn_b = sb_en && b[WIDTH-1];
    assign mag_a = sgn_a ? -a : a;
    assign mag_b = sgn_b ? -b : b;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // A set carry-out bit means the partial remainder exceeds any divisor.
    assign div_rs   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_rs[WIDTH-1:0] - opnd_q;
    assign div_ge   = div_rs[WIDTH] || (div_rs[WIDTH-1:0] >= opnd_q);
    assign div_nr   = div_ge ? div_diff : div_rs[WIDTH-1:0];

    always_comb begin
        if (state_q == MUL)
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        else
            acc_d = {div_nr, acc_q[WIDTH-2:0], div_ge};
    end

    assign prod = negq_q ? -acc_d : acc_d;
    assign quo  = (opnd_q == '0) ? '1
                : (negq_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0]);
    assign rem  = negr_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];

    always_comb begin
        if (state_q == MUL)
            mdu_res = (fn_q == 3'b000) ? prod[WIDTH-1:0]
                                       : prod[2*WIDTH-1:WIDTH];
        else
            mdu_res = fn_q[1] ? rem : quo;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (i_req_vld)
                      state_d = !is_m ? DONE : (i_alu_op[2] ? DIV : MUL);
            MUL,
            DIV:  if (last) state_d = DONE;
            DONE: if (i_rsp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            fn_q   <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            insn_q <= 1'b0;
        end else if (hs) begin
            cnt_q <= '0;
            fn_q  <= i_alu_op[2:0];
            if (is_m) begin
                acc_q  <= {{WIDTH{1'b0}}, i_alu_op[2] ? mag_a : mag_b};
                opnd_q <= i_alu_op[2] ? mag_b : mag_a;
                negq_q <= sgn_a ^ sgn_b;
                negr_q <= sgn_a;
                insn_q <= 1'b1;
            end else begin
                res_q  <= base_res;
                insn_q <= base_ok;
            end
        end else if (state_q == MUL || state_q == DIV) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (last) res_q <= mdu_res;
        end
    end

    assign o_req_rdy  = state_q == IDLE;
    assign o_rsp_vld  = state_q == DONE;
    assign o_alu_data = res_q;
    assign o_insn_vld = insn_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq at WIDTH=32 and WIDTH=8.
`timescale 1ns/1ps
module tb_alu_mdu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld32 = 1'b0, vld8 = 1'b0;
    logic        rdy32, rdy8, rsp32, rsp8, iv32, iv8;
    logic        rsp_rdy = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] data32;
    logic [7:0]  data8;
    int          n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    alu_mdu_seq #(.WIDTH(32)) u_dut32 (
        .i_clk(clk), .i_rst(rst),
        .i_req_vld(vld32), .o_req_rdy(rdy32),
        .i_alu_op(op), .i_operand_a(a), .i_operand_b(b),
        .o_rsp_vld(rsp32), .i_rsp_rdy(rsp_rdy),
        .o_alu_data(data32), .o_insn_vld(iv32)
    );

    alu_mdu_seq #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst),
        .i_req_vld(vld8), .o_req_rdy(rdy8),
        .i_alu_op(op), .i_operand_a(a[7:0]), .i_operand_b(b[7:0]),
        .o_rsp_vld(rsp8), .i_rsp_rdy(rsp_rdy),
        .o_alu_data(data8), .o_insn_vld(iv8)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input bit w8,
                         input logic [4:0] f, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [31:0] exp,
                         input logic iv_exp, input int lat_exp);
        int lat;
        @(negedge clk);
        op = f; a = xa; b = xb;
        if (w8) vld8 = 1'b1;
        else    vld32 = 1'b1;
        chk({tag, ".rdy"}, w8 ? rdy8 : rdy32, 1);
        @(posedge clk); #1;
        vld32 = 1'b0; vld8 = 1'b0;
        a = ~a; b = ~b; op = 5'b01111;
        lat = 1;
        while (!(w8 ? rsp8 : rsp32) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, lat_exp);
        chk({tag, ".data"}, w8 ? {24'b0, data8} : data32, exp);
        chk({tag, ".iv"}, w8 ? iv8 : iv32, iv_exp);
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        chk({tag, ".idle"}, w8 ? rdy8 : rdy32, 1);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.rdy", rdy32, 1);
        chk("rst.rsp", rsp32, 0);
        chk("rst.data", data32, 0);
        chk("rst.iv", iv32, 0);

        apply("add",    0, 5'b00000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 1);
        apply("sub",    0, 5'b01000, 32'h0, 32'h1, 32'hFFFFFFFF, 1, 1);
        apply("sll",    0, 5'b00001, 32'h1, 32'h21, 32'h2, 1, 1);
        apply("slt",    0, 5'b00010, 32'hFFFFFFFF, 32'h1, 32'h1, 1, 1);
        apply("sltu",   0, 5'b00011, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1);
        apply("xor",    0, 5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 1);
        apply("srl",    0, 5'b00101, 32'h80000000, 32'h4, 32'h08000000, 1, 1);
        apply("sra",    0, 5'b01101, 32'h80000000, 32'h24, 32'hF8000000, 1, 1);
        apply("or",     0, 5'b00110, 32'h0F, 32'hF0, 32'hFF, 1, 1);
        apply("and",    0, 5'b00111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1, 1);
        apply("ill0",   0, 5'b01111, 32'h5, 32'h6, 32'h0, 0, 1);
        apply("ill1",   0, 5'b11000, 32'h5, 32'h6, 32'h0, 0, 1);

        apply("mulh",   0, 5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1, 33);
        apply("mulhu",  0, 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 33);
        apply("mul",    0, 5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1, 33);
        apply("mulhsu", 0, 5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 33);
        apply("mul2",   0, 5'b10000, 32'h12345678, 32'h10, 32'h23456780, 1, 33);

        apply("div",    0, 5'b10100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1, 33);
        apply("rem",    0, 5'b10110, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1, 33);
        apply("divu0",  0, 5'b10101, 32'h5, 32'h0, 32'hFFFFFFFF, 1, 33);
        apply("remu0",  0, 5'b10111, 32'h5, 32'h0, 32'h5, 1, 33);
        apply("div0s",  0, 5'b10100, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF, 1, 33);
        apply("rem0s",  0, 5'b10110, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 1, 33);
        apply("removf", 0, 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 33);
        apply("divovf", 0, 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 33);
        apply("divu",   0, 5'b10101, 32'd100, 32'd7, 32'd14, 1, 33);
        apply("remu",   0, 5'b10111, 32'd100, 32'd7, 32'd2, 1, 33);

        apply("w8.mulh",  1, 5'b10001, 32'hFF, 32'hFF, 32'h00, 1, 9);
        apply("w8.mulhu", 1, 5'b10011, 32'hFF, 32'hFF, 32'hFE, 1, 9);
        apply("w8.mul",   1, 5'b10000, 32'hFF, 32'hFF, 32'h01, 1, 9);
        apply("w8.div",   1, 5'b10100, 32'hF9, 32'h02, 32'hFD, 1, 9);

        // Backpressure in DONE with stray requests
        @(negedge clk);
        op = 5'b00000; a = 32'd5; b = 32'd6; vld32 = 1'b1;
        @(posedge clk); #1;
        vld32 = 1'b0;
        chk("bp.rsp", rsp32, 1);
        for (int i = 0; i < 10; i++) begin
            vld32 = 1'b1; op = 5'b01000; a = 32'd1; b = 32'd1;
            @(posedge clk); #1;
            chk("bp.data", data32, 32'd11);
            chk("bp.rdy", rdy32, 0);
            chk("bp.hold", rsp32, 1);
        end
        vld32 = 1'b0;
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        chk("bp.rel.rsp", rsp32, 0);
        chk("bp.rel.rdy", rdy32, 1);
        @(posedge clk); #1;
        chk("bp.noq", rsp32, 0);

        // Reset in the middle of a divide
        @(negedge clk);
        op = 5'b10100; a = 32'd100; b = 32'd7; vld32 = 1'b1;
        @(posedge clk); #1;
        vld32 = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.rsp", rsp32, 0);
        chk("abort.rdy", rdy32, 1);
        chk("abort.data", data32, 0);
        chk("abort.iv", iv32, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp32) seen = 1;
        end
        chk("abort.silent", seen, 0);
        apply("post", 0, 5'b00000, 32'd3, 32'd4, 32'd7, 1, 1);

        // Reset wins over a simultaneous handshake
        @(negedge clk);
        rst = 1'b1; vld32 = 1'b1; op = 5'b00000; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        rst = 1'b0; vld32 = 1'b0;
        chk("rstprio.rsp", rsp32, 0);
        chk("rstprio.rdy", rdy32, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
